// File: rtl/mandelbrot_engine_sched.sv
// Frame scheduler that shares one coordinate stream among NE mandelbrot engines
// and merges their results round-robin into a single registered output stream.
module mandelbrot_engine_sched #(
  parameter int NE   = 4,
  parameter int FPW  = 27,
  parameter int AW   = 19,
  parameter int IW   = 8,
  parameter int NPIX = 307200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             coord_init,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [FPW-1:0]   in_x,
  input  logic [FPW-1:0]   in_y,
  input  logic [AW-1:0]    in_adr,
  output logic [NE-1:0]    eng_vld,
  input  logic [NE-1:0]    eng_rdy,
  output logic [FPW-1:0]   eng_x,
  output logic [FPW-1:0]   eng_y,
  output logic [AW-1:0]    eng_adr,
  input  logic [NE-1:0]    res_vld,
  output logic [NE-1:0]    res_rdy,
  input  logic [NE*IW-1:0] res_niter,
  input  logic [NE*AW-1:0] res_adr,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [IW-1:0]    out_niter,
  output logic [AW-1:0]    out_adr
);

  localparam int CNTW = $clog2(NPIX + 1);
  localparam int PW   = (NE > 1) ? $clog2(NE) : 1;
  localparam logic [CNTW-1:0] NPIX_C = CNTW'(NPIX);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   dptr_q, dptr_d, rptr_q, rptr_d;
  logic [PW-1:0]   sel, gnt;
  logic            sel_found, gnt_found;
  logic [CNTW-1:0] issued_q, issued_d, retired_q, retired_d;
  logic            out_vld_q, out_vld_d;
  logic [IW-1:0]   out_niter_q, out_niter_d;
  logic [AW-1:0]   out_adr_q, out_adr_d;
  logic            load_en, in_hs, out_hs;

  // Index k steps past base, wrapping at NE (NE need not be a power of two).
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NE) s = s - NE;
    return PW'(s);
  endfunction

  // Pointer to the engine after p, wrapping at NE.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(NE - 1)) ? '0 : p + 1'b1;
  endfunction

  // Round-robin searches: first ready engine from dptr, first finished engine from rptr.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    gnt       = '0;
    gnt_found = 1'b0;
    for (int k = 0; k < NE; k++) begin
      if (!sel_found && eng_rdy[wrap_add(dptr_q, k)]) begin
        sel_found = 1'b1;
        sel       = wrap_add(dptr_q, k);
      end
      if (!gnt_found && res_vld[wrap_add(rptr_q, k)]) begin
        gnt_found = 1'b1;
        gnt       = wrap_add(rptr_q, k);
      end
    end
  end

  // Handshake signals; everything is held off while the clock enable is low.
  always_comb begin
    in_rdy  = clk_en && (state_q == S_RUN) && (issued_q < NPIX_C) && sel_found;
    eng_vld = (in_rdy && in_vld) ? (NE'(1) << sel) : '0;
    in_hs   = in_rdy && in_vld;
    load_en = clk_en && ((state_q == S_RUN) || (state_q == S_DRAIN)) &&
              (!out_vld_q || out_rdy);
    res_rdy = (load_en && gnt_found) ? (NE'(1) << gnt) : '0;
    out_hs  = out_vld_q && out_rdy;
  end

  // Next-state logic for the frame FSM, counters, pointers and output register.
  always_comb begin
    state_d     = state_q;
    issued_d    = issued_q;
    retired_d   = retired_q;
    dptr_d      = dptr_q;
    rptr_d      = rptr_q;
    out_vld_d   = out_vld_q;
    out_niter_d = out_niter_q;
    out_adr_d   = out_adr_q;
    if (in_hs) begin
      issued_d = issued_q + CNTW'(1);
      dptr_d   = next_ptr(sel);
    end
    if (out_hs && (retired_q != NPIX_C)) retired_d = retired_q + CNTW'(1);
    if (load_en && gnt_found) begin
      out_vld_d   = 1'b1;
      out_niter_d = res_niter[gnt*IW +: IW];
      out_adr_d   = res_adr[gnt*AW +: AW];
      rptr_d      = next_ptr(gnt);
    end else if (out_rdy) begin
      out_vld_d = 1'b0;
    end
    case (state_q)
      S_IDLE:  if (start) state_d = S_INIT;
      S_INIT: begin
        issued_d  = '0;
        retired_d = '0;
        state_d   = S_RUN;
      end
      S_RUN:   if (issued_d == NPIX_C) state_d = S_DRAIN;
      S_DRAIN: if (retired_d == NPIX_C) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register; frozen whenever the clock enable is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      issued_q    <= '0;
      retired_q   <= '0;
      dptr_q      <= '0;
      rptr_q      <= '0;
      out_vld_q   <= 1'b0;
      out_niter_q <= '0;
      out_adr_q   <= '0;
    end else if (clk_en) begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      retired_q   <= retired_d;
      dptr_q      <= dptr_d;
      rptr_q      <= rptr_d;
      out_vld_q   <= out_vld_d;
      out_niter_q <= out_niter_d;
      out_adr_q   <= out_adr_d;
    end
  end

  // Status decodes straight from the state register.
  always_comb begin
    busy       = (state_q == S_INIT) || (state_q == S_RUN) || (state_q == S_DRAIN);
    done       = (state_q == S_DONE);
    coord_init = (state_q == S_INIT);
  end

  assign eng_x     = in_x;
  assign eng_y     = in_y;
  assign eng_adr   = in_adr;
  assign out_vld   = out_vld_q;
  assign out_niter = out_niter_q;
  assign out_adr   = out_adr_q;

endmodule

// File: tb/tb_mandelbrot_engine_sched.sv
// Bench for mandelbrot_engine_sched: directed vector table plus hand-written frame sequences.
module tb_mandelbrot_engine_sched;

  localparam int NE   = 4;
  localparam int FPW  = 27;
  localparam int AW   = 19;
  localparam int IW   = 8;
  localparam int NPIX = 16;

  logic             clk, rst, clk_en, start;
  logic             busy, done, coord_init;
  logic             in_vld, in_rdy;
  logic [FPW-1:0]   in_x, in_y, eng_x, eng_y;
  logic [AW-1:0]    in_adr, eng_adr, out_adr;
  logic [NE-1:0]    eng_vld, eng_rdy, res_vld, res_rdy;
  logic [NE*IW-1:0] res_niter;
  logic [NE*AW-1:0] res_adr;
  logic             out_vld, out_rdy;
  logic [IW-1:0]    out_niter;

  mandelbrot_engine_sched #(.NE(NE), .FPW(FPW), .AW(AW), .IW(IW), .NPIX(NPIX)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .start(start),
    .busy(busy), .done(done), .coord_init(coord_init),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_x(in_x), .in_y(in_y), .in_adr(in_adr),
    .eng_vld(eng_vld), .eng_rdy(eng_rdy), .eng_x(eng_x), .eng_y(eng_y), .eng_adr(eng_adr),
    .res_vld(res_vld), .res_rdy(res_rdy), .res_niter(res_niter), .res_adr(res_adr),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_niter(out_niter), .out_adr(out_adr)
  );

  // Free-running clock, active edge is posedge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, wanted completion");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic       clk_en, start, in_vld, out_rdy;
    logic [3:0] eng_rdy, res_vld;
    logic       x_init, x_busy, x_in_rdy, x_out_vld;
    logic [3:0] x_eng_vld, x_res_rdy;
    int         x_eng;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add_vec(input logic ce, input logic st, input logic iv, input logic ordy,
                                  input logic [3:0] er, input logic [3:0] rv,
                                  input logic xi, input logic xb, input logic xir, input logic xov,
                                  input logic [3:0] xev, input logic [3:0] xrr, input int xe);
    vec_t v;
    v.clk_en = ce; v.start = st; v.in_vld = iv; v.out_rdy = ordy;
    v.eng_rdy = er; v.res_vld = rv;
    v.x_init = xi; v.x_busy = xb; v.x_in_rdy = xir; v.x_out_vld = xov;
    v.x_eng_vld = xev; v.x_res_rdy = xrr; v.x_eng = xe;
    vecs.push_back(v);
  endfunction

  // Engine i always presents niter 10+i and address 256+i.
  task automatic set_fixed_results();
    for (int i = 0; i < NE; i++) begin
      res_niter[i*IW +: IW] = IW'(10 + i);
      res_adr[i*AW +: AW]   = AW'(256 + i);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    clk_en  = v.clk_en;
    start   = v.start;
    in_vld  = v.in_vld;
    out_rdy = v.out_rdy;
    eng_rdy = v.eng_rdy;
    res_vld = v.res_vld;
  endtask

  task automatic check_output(input vec_t v, input int idx);
    check($sformatf("vec%0d_coord_init", idx), coord_init, v.x_init);
    check($sformatf("vec%0d_busy", idx), busy, v.x_busy);
    check($sformatf("vec%0d_done", idx), done, 1'b0);
    check($sformatf("vec%0d_in_rdy", idx), in_rdy, v.x_in_rdy);
    check($sformatf("vec%0d_eng_vld", idx), eng_vld, v.x_eng_vld);
    check($sformatf("vec%0d_res_rdy", idx), res_rdy, v.x_res_rdy);
    check($sformatf("vec%0d_out_vld", idx), out_vld, v.x_out_vld);
    if (v.x_eng >= 0) begin
      check($sformatf("vec%0d_out_adr", idx), out_adr, 256 + v.x_eng);
      check($sformatf("vec%0d_out_niter", idx), out_niter, 10 + v.x_eng);
    end
  endtask

  task automatic run_vectors(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      @(posedge clk); #1;
      apply_stimulus(vecs[i]);
      @(negedge clk);
      check_output(vecs[i], i);
    end
  endtask

  // Hold reset with busy-looking inputs; everything must read as idle.
  task automatic do_reset();
    rst = 1'b0; clk_en = 1'b1; start = 1'b1; in_vld = 1'b1;
    eng_rdy = '1; res_vld = '1; out_rdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_coord_init", coord_init, 1'b0);
    check("reset_out_vld", out_vld, 1'b0);
    check("reset_out_niter", out_niter, 0);
    check("reset_out_adr", out_adr, 0);
    check("reset_in_rdy", in_rdy, 1'b0);
    check("reset_eng_vld", eng_vld, 0);
    check("reset_res_rdy", res_rdy, 0);
    start = 1'b0; in_vld = 1'b0; eng_rdy = '0; res_vld = '0;
    rst = 1'b1;
  endtask

  // Full frame with single-slot engine models and random stalls everywhere.
  task automatic full_frame_test();
    logic       slot_full [NE];
    int         slot_adr [NE];
    logic [3:0] pend_push, pend_pop;
    logic       pend_issue;
    int         pend_adr;
    int         n_issue, n_ret, n_done, n_init, viol, post;
    logic       last_seen;
    logic [15:0] mask;
    for (int i = 0; i < NE; i++) begin slot_full[i] = 1'b0; slot_adr[i] = 0; end
    pend_push = '0; pend_pop = '0; pend_issue = 1'b0; pend_adr = 0;
    n_issue = 0; n_ret = 0; n_done = 0; n_init = 0; viol = 0; post = 0;
    last_seen = 1'b0; mask = '0; in_adr = '0;
    @(posedge clk); #1;
    clk_en = 1'b1; start = 1'b1; out_rdy = 1'b1; in_vld = 1'b0; eng_rdy = '0; res_vld = '0;
    for (int cyc = 0; cyc < 600 && post < 2; cyc++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NE; i++) begin
        if (pend_pop[i]) slot_full[i] = 1'b0;
        if (pend_push[i]) begin slot_full[i] = 1'b1; slot_adr[i] = pend_adr; end
      end
      if (pend_issue) in_adr = in_adr + AW'(1);
      if (last_seen) post++;
      start   = (post == 1) ? 1'b1 : ((post == 0) && ($urandom_range(0, 4) == 0));
      in_vld  = (post == 0) && ($urandom_range(0, 3) != 0);
      out_rdy = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < NE; i++) begin
        eng_rdy[i] = !slot_full[i] && ($urandom_range(0, 3) != 0);
        res_vld[i] = slot_full[i];
        res_adr[i*AW +: AW]   = AW'(slot_adr[i]);
        res_niter[i*IW +: IW] = IW'(slot_adr[i] + 3);
      end
      @(negedge clk);
      pend_issue = in_vld && in_rdy;
      pend_adr   = int'(in_adr);
      pend_push  = pend_issue ? eng_vld : 4'b0000;
      pend_pop   = res_rdy & res_vld;
      if (pend_issue) n_issue++;
      if ((eng_vld & ~eng_rdy) != 4'b0000) viol++;
      if ((eng_vld != 4'b0000) != pend_issue) viol++;
      if ((eng_vld & (eng_vld - 4'd1)) != 4'b0000) viol++;
      if (eng_adr != in_adr) viol++;
      if (coord_init) n_init++;
      if (done) n_done++;
      if (out_vld && out_rdy) begin
        n_ret++;
        mask[out_adr[3:0]] = 1'b1;
        if (out_niter != IW'(out_adr + 3)) viol++;
        if (n_ret == NPIX) last_seen = 1'b1;
      end
      if (post == 1) begin
        check("frame_done_after_last", done, 1'b1);
        check("frame_busy_falls_with_done", busy, 1'b0);
      end else if (post == 2) begin
        check("start_at_done_ignored_init", coord_init, 1'b0);
        check("start_at_done_ignored_busy", busy, 1'b0);
        check("done_single_cycle", done, 1'b0);
      end
    end
    start = 1'b0; in_vld = 1'b0; eng_rdy = '0; res_vld = '0;
    check("frame_completed", post, 2);
    check("frame_issued", n_issue, NPIX);
    check("frame_retired", n_ret, NPIX);
    check("frame_addr_set", mask, 16'hFFFF);
    check("frame_done_pulses", n_done, 1);
    check("frame_init_pulses", n_init, 1);
    check("frame_protocol_errors", viol, 0);
  endtask

  // Reset asserted mid-RUN after seven transfers, then a clean restart.
  task automatic midframe_reset_test();
    int n_xfer;
    set_fixed_results();
    @(posedge clk); #1;
    clk_en = 1'b1; start = 1'b1; eng_rdy = 4'hF; in_vld = 1'b1; res_vld = 4'b0001; out_rdy = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    check("mid_busy_before", busy, 1'b1);
    check("mid_out_vld_before", out_vld, 1'b1);
    rst = 1'b0;
    #1;
    check("mid_reset_busy", busy, 1'b0);
    check("mid_reset_out_vld", out_vld, 1'b0);
    check("mid_reset_coord_init", coord_init, 1'b0);
    check("mid_reset_in_rdy", in_rdy, 1'b0);
    check("mid_reset_eng_vld", eng_vld, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("restart_coord_init", coord_init, 1'b1);
    n_xfer = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 0) check("restart_first_engine", eng_vld, 4'b0001);
      if (in_rdy && in_vld) n_xfer++;
    end
    check("restart_transfers", n_xfer, 16);
    @(posedge clk);
    @(negedge clk);
    check("restart_in_rdy_low", in_rdy, 1'b0);
    in_vld = 1'b0; eng_rdy = '0; res_vld = '0;
  endtask

  initial begin
    int a_lo, a_hi, b_lo, b_hi, c_lo, c_hi;
    rst = 1'b0; clk_en = 1'b1; start = 1'b0; in_vld = 1'b0; out_rdy = 1'b1;
    eng_rdy = '0; res_vld = '0; in_adr = AW'(5);
    in_x = FPW'(27'h123456); in_y = FPW'(27'h0ABCDE);
    set_fixed_results();

    // Dispatch rotation with every engine ready.
    a_lo = vecs.size();
    add_vec(1, 1, 1, 1, 4'hF, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, -1);
    add_vec(1, 0, 1, 1, 4'hF, 4'h0, 1, 1, 0, 0, 4'h0, 4'h0, -1);
    for (int k = 0; k < NPIX; k++)
      add_vec(1, 0, 1, 1, 4'hF, 4'h0, 0, 1, 1, 0, 4'(1 << (k % 4)), 4'h0, -1);
    add_vec(1, 0, 1, 1, 4'hF, 4'h0, 0, 1, 0, 0, 4'h0, 4'h0, -1);
    add_vec(1, 0, 1, 1, 4'hF, 4'h0, 0, 1, 0, 0, 4'h0, 4'h0, -1);
    a_hi = vecs.size();

    // Sparse ready mask, clock-enable freeze and an idle coordinate cycle.
    b_lo = vecs.size();
    add_vec(1, 1, 0, 1, 4'hF,    4'h0, 0, 0, 0, 0, 4'h0,    4'h0, -1);
    add_vec(1, 0, 0, 1, 4'hF,    4'h0, 1, 1, 0, 0, 4'h0,    4'h0, -1);
    add_vec(1, 0, 1, 1, 4'b0001, 4'h0, 0, 1, 1, 0, 4'b0001, 4'h0, -1);
    add_vec(1, 0, 1, 1, 4'b0101, 4'h0, 0, 1, 1, 0, 4'b0100, 4'h0, -1);
    add_vec(0, 0, 1, 1, 4'b0101, 4'h0, 0, 1, 0, 0, 4'b0000, 4'h0, -1);
    add_vec(1, 0, 1, 1, 4'b0101, 4'h0, 0, 1, 1, 0, 4'b0001, 4'h0, -1);
    add_vec(1, 0, 0, 1, 4'b0101, 4'h0, 0, 1, 1, 0, 4'b0000, 4'h0, -1);
    add_vec(1, 0, 1, 1, 4'b0101, 4'h0, 0, 1, 1, 0, 4'b0100, 4'h0, -1);
    add_vec(1, 0, 1, 1, 4'b0000, 4'h0, 0, 1, 0, 0, 4'b0000, 4'h0, -1);
    add_vec(1, 0, 1, 1, 4'b0101, 4'h0, 0, 1, 1, 0, 4'b0001, 4'h0, -1);
    b_hi = vecs.size();

    // Result merge: rotation, downstream stall, drain and freeze.
    c_lo = vecs.size();
    add_vec(1, 1, 0, 1, 4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 4'b0000, -1);
    add_vec(1, 0, 0, 1, 4'h0, 4'hF, 1, 1, 0, 0, 4'h0, 4'b0000, -1);
    add_vec(1, 0, 0, 1, 4'h0, 4'hF, 0, 1, 0, 0, 4'h0, 4'b0001, -1);
    add_vec(1, 0, 0, 1, 4'h0, 4'hF, 0, 1, 0, 1, 4'h0, 4'b0010, 0);
    add_vec(1, 0, 0, 1, 4'h0, 4'hF, 0, 1, 0, 1, 4'h0, 4'b0100, 1);
    add_vec(1, 0, 0, 1, 4'h0, 4'hF, 0, 1, 0, 1, 4'h0, 4'b1000, 2);
    add_vec(1, 0, 0, 1, 4'h0, 4'hF, 0, 1, 0, 1, 4'h0, 4'b0001, 3);
    add_vec(1, 0, 0, 1, 4'h0, 4'hF, 0, 1, 0, 1, 4'h0, 4'b0010, 0);
    for (int k = 0; k < 5; k++)
      add_vec(1, 0, 0, 0, 4'h0, 4'hF, 0, 1, 0, 1, 4'h0, 4'b0000, 1);
    add_vec(1, 0, 0, 1, 4'h0, 4'hF, 0, 1, 0, 1, 4'h0, 4'b0100, 1);
    add_vec(1, 0, 0, 1, 4'h0, 4'hF, 0, 1, 0, 1, 4'h0, 4'b1000, 2);
    add_vec(1, 0, 0, 1, 4'h0, 4'h0, 0, 1, 0, 1, 4'h0, 4'b0000, 3);
    add_vec(1, 0, 0, 1, 4'h0, 4'h0, 0, 1, 0, 0, 4'h0, 4'b0000, -1);
    add_vec(0, 0, 0, 1, 4'h0, 4'hF, 0, 1, 0, 0, 4'h0, 4'b0000, -1);
    add_vec(1, 0, 0, 1, 4'h0, 4'hF, 0, 1, 0, 0, 4'h0, 4'b0001, -1);
    c_hi = vecs.size();

    do_reset();
    run_vectors(a_lo, a_hi);
    do_reset();
    run_vectors(b_lo, b_hi);
    do_reset();
    run_vectors(c_lo, c_hi);
    do_reset();
    full_frame_test();
    do_reset();
    midframe_reset_test();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mandelbrot_engine_sched.md
Name: mandelbrot_engine_sched

Overview:
- Frame-level scheduler that shares one mandelbrot coordinate stream between NE parallel mandelbrot_calc engines.
- Sits between the coordinate generator and the engines, and between the engines and the result FIFO that feeds video memory.
- Sequences each frame: initialises the coordinate generator, dispatches coordinates round-robin to ready engines, and merges results round-robin into one registered output stream.
- Counts retired pixels and signals frame completion.

Parameters:
- NE, 4, number of mandelbrot_calc engines (2..8).
- FPW, 27, fixed-point coordinate width.
- AW, 19, pixel address width.
- IW, 8, iteration-count width.
- NPIX, 307200, pixels per frame.
- CNTW, $clog2(NPIX+1), width of the pixel counters (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- clk_en  in  1  clock enable; all state frozen when low.
- start  in  1  frame start request.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when the last pixel is retired.
- coord_init  out  1  one-cycle init pulse to the coordinate generator.
- in_vld  in  1  coordinate valid.
- in_rdy  out  1  coordinate accepted.
- in_x  in  FPW  coordinate x.
- in_y  in  FPW  coordinate y.
- in_adr  in  AW  coordinate address.
- eng_vld  out  NE  per-engine input valid.
- eng_rdy  in  NE  per-engine input ready.
- eng_x  out  FPW  broadcast x (equals in_x).
- eng_y  out  FPW  broadcast y (equals in_y).
- eng_adr  out  AW  broadcast address (equals in_adr).
- res_vld  in  NE  per-engine result valid.
- res_rdy  out  NE  per-engine result ready.
- res_niter  in  NE*IW  packed results; engine i at [i*IW +: IW].
- res_adr  in  NE*AW  packed addresses; engine i at [i*AW +: AW].
- out_vld  out  1  merged result valid.
- out_rdy  in  1  downstream ready (FIFO not full).
- out_niter  out  IW  merged iteration count.
- out_adr  out  AW  merged address.

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE; busy, done, coord_init, out_vld = 0; out_niter, out_adr = 0; dispatch pointer dptr = 0; result pointer rptr = 0; issued and retired counters = 0.
- Combinational outputs (in_rdy, eng_vld, res_rdy) are forced to 0 whenever clk_en=0 or the FSM is not in a state that permits them.
- FSM states:
  - IDLE: in_rdy=0. start=1 -> INIT.
  - INIT: coord_init=1 for exactly one cycle; counters clear; busy=1 -> RUN.
  - RUN: dispatch enabled. When the issued count reaches NPIX -> DRAIN.
  - DRAIN: dispatch disabled; results still collected. When the retired count reaches NPIX -> DONE.
  - DONE: done=1 for one cycle; busy=0 -> IDLE.
- busy=1 in INIT, RUN and DRAIN.
- start is ignored unless the FSM is in IDLE. A start coinciding with DONE is ignored.
- Dispatch (RUN only, zero latency):
  - sel = first i with eng_rdy[i]=1, searching from dptr upward modulo NE.
  - in_rdy = any(eng_rdy) && issued<NPIX.
  - eng_vld = onehot(sel) & in_vld.
  - On handshake (in_vld && in_rdy): issued++; dptr = (sel+1) mod NE.
  - eng_vld is never asserted for an engine with eng_rdy=0.
- Result merge (RUN and DRAIN; 1-cycle latency through the output register):
  - Output register loads when empty or being consumed (!out_vld || out_rdy).
  - g = first i with res_vld[i]=1, searching from rptr upward modulo NE.
  - res_rdy = onehot(g) when the register loads; otherwise all zero.
  - On load: out_niter, out_adr = engine g data; out_vld=1; rptr = (g+1) mod NE.
  - With no res_vld and out_rdy=1: out_vld drops to 0.
  - out_vld, out_niter and out_adr hold stable while out_vld && !out_rdy.
  - Full back-to-back throughput: one result per cycle.
- retired++ on each out handshake (out_vld && out_rdy).
- Counters saturate; neither ever exceeds NPIX.
- Fairness: an engine with continuous res_vld is granted within NE loads.
- Mid-frame reset: everything returns to reset values immediately. Any in-flight engine results are the engines' responsibility; they are reset on the same rst.

Test Plan:
- NE=4, NPIX=16, all eng_rdy=1, in_vld=1, out_rdy=1: start pulse -> coord_init one cycle after start; eng_vld rotates 0001,0010,0100,1000 over 16 cycles; in_rdy drops after the 16th transfer.
- eng_rdy=0101 steady, dptr=1: next transfer goes to engine 2, then engine 0, then engine 2; engines 1 and 3 never see eng_vld.
- All res_vld=1111 held, out_rdy=1: grants cycle engine 0,1,2,3,0...; out_adr follows res_adr of each granted engine one cycle later.
- out_rdy=0 for 5 cycles with out_vld=1: out_niter/out_adr stable, res_rdy=0000; out_rdy back high -> next load in the same cycle.
- Full frame, NPIX=16, random stalls: done pulses exactly once after the 16th out handshake; busy falls in the same cycle; start during busy has no effect.
- Assert rst=0 mid-RUN with issued=7: busy, out_vld, coord_init = 0 immediately; a new start restarts counting from 0.
